// File: rtl/hdmi_timing_gen.sv
// Raster timing generator: hs/vs/de, pixel coordinates and 8-bar test pattern from shadowed setup.
// Latency 1 cycle counters->outputs; no backpressure, setup__ACK always follows setup__ENA by one cycle.
module hdmi_timing_gen #(
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   DATA_WIDTH = 36
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  setup__ENA,
  input  logic [15:0]           setup__ahEnd,
  input  logic [15:0]           setup__ahFrontEnd,
  input  logic [7:0]            setup__ahBackSync,
  input  logic [7:0]            setup__ahSyncWidth,
  input  logic [15:0]           setup__avEnd,
  input  logic [15:0]           setup__avFrontEnd,
  input  logic [7:0]            setup__avBackSync,
  input  logic [7:0]            setup__avSyncWidth,
  output logic                  setup__ACK,
  output logic                  param_err,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic [15:0]           x,
  output logic [15:0]           y,
  output logic                  frame_start,
  output logic [DATA_WIDTH-1:0] pixel
);

  localparam int CW = DATA_WIDTH / 3;

  typedef struct packed {
    logic [15:0] ah_end;
    logic [15:0] ah_fe;
    logic [7:0]  ah_bs;
    logic [7:0]  ah_sw;
    logic [15:0] av_end;
    logic [15:0] av_fe;
    logic [7:0]  av_bs;
    logic [7:0]  av_sw;
  } timing_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  timing_t               shadow_q, shadow_d;
  timing_t               act_q, act_d;
  timing_t               setup_in;
  logic                  shadow_ok_q, shadow_ok_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [15:0]           h_q, h_d;
  logic [15:0]           v_q, v_d;
  logic [2:0]            bar_q, bar_d;
  logic [15:0]           pos_q, pos_d;
  logic                  hs_q, hs_d;
  logic                  vs_q, vs_d;
  logic                  de_q, de_d;
  logic                  fs_q, fs_d;
  logic [15:0]           x_q, x_d;
  logic [15:0]           y_q, y_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;

  logic [16:0] h_sum, v_sum;
  logic        setup_ok;
  logic        line_start;
  logic [15:0] bar_w;
  logic        run;
  logic [15:0] hs_start, hs_stop, vs_start, vs_stop;

  always_comb begin
    setup_in.ah_end = setup__ahEnd;
    setup_in.ah_fe  = setup__ahFrontEnd;
    setup_in.ah_bs  = setup__ahBackSync;
    setup_in.ah_sw  = setup__ahSyncWidth;
    setup_in.av_end = setup__avEnd;
    setup_in.av_fe  = setup__avFrontEnd;
    setup_in.av_bs  = setup__avBackSync;
    setup_in.av_sw  = setup__avSyncWidth;
    // 17-bit sums so a large porch cannot wrap past End and look legal
    h_sum = {1'b0, setup__ahFrontEnd} + {9'd0, setup__ahBackSync} + {9'd0, setup__ahSyncWidth};
    v_sum = {1'b0, setup__avFrontEnd} + {9'd0, setup__avBackSync} + {9'd0, setup__avSyncWidth};
    setup_ok = (setup__ahEnd != 16'd0) && (setup__ahFrontEnd != 16'd0) &&
               (h_sum < {1'b0, setup__ahEnd}) &&
               (setup__avEnd != 16'd0) && (setup__avFrontEnd != 16'd0) &&
               (v_sum < {1'b0, setup__avEnd});
  end

  always_comb begin
    shadow_d    = shadow_q;
    shadow_ok_d = shadow_ok_q;
    err_d       = err_q;
    ack_d       = setup__ENA;
    if (setup__ENA) begin
      if (setup_ok) begin
        shadow_d    = setup_in;
        shadow_ok_d = 1'b1;
        err_d       = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Raster counters; active timing only changes where h and v both restart
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    h_d        = h_q;
    v_d        = v_q;
    bar_d      = bar_q;
    pos_d      = pos_q;
    line_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ack_q && shadow_ok_q) begin
          state_d    = ST_RUN;
          act_d      = shadow_q;
          h_d        = '0;
          v_d        = '0;
          line_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (h_q == act_q.ah_end - 16'd1) begin
          h_d        = '0;
          line_start = 1'b1;
          if (v_q == act_q.av_end - 16'd1) begin
            v_d   = '0;
            act_d = shadow_q;
          end else begin
            v_d = v_q + 16'd1;
          end
        end else begin
          h_d = h_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bar index tracked incrementally; leftover pixels stay in bar 7
    bar_w = {3'b000, act_d.ah_fe[15:3]};
    if (line_start) begin
      pos_d = '0;
      bar_d = (bar_w == 16'd0) ? 3'd7 : 3'd0;
    end else if (state_q == ST_RUN) begin
      if (bar_q != 3'd7 && pos_q == bar_w - 16'd1) begin
        bar_d = bar_q + 3'd1;
        pos_d = '0;
      end else begin
        pos_d = pos_q + 16'd1;
      end
    end
  end

  always_comb begin
    run      = (state_q == ST_RUN);
    hs_stop  = act_q.ah_end - {8'd0, act_q.ah_bs};
    hs_start = hs_stop - {8'd0, act_q.ah_sw};
    vs_stop  = act_q.av_end - {8'd0, act_q.av_bs};
    vs_start = vs_stop - {8'd0, act_q.av_sw};
    de_d     = run && (h_q < act_q.ah_fe) && (v_q < act_q.av_fe);
    hs_d     = (run && h_q >= hs_start && h_q < hs_stop) ? HS_POL : ~HS_POL;
    vs_d     = (run && v_q >= vs_start && v_q < vs_stop) ? VS_POL : ~VS_POL;
    fs_d     = run && (h_q == 16'd0) && (v_q == 16'd0);
    x_d      = de_d ? h_q : x_q;
    y_d      = de_d ? v_q : y_q;
    pix_d    = '0;
    if (de_d) begin
      pix_d[3*CW-1:0] = {{CW{bar_q[2]}}, {CW{bar_q[1]}}, {CW{bar_q[0]}}};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      act_q       <= '0;
      shadow_ok_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      bar_q       <= '0;
      pos_q       <= '0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      act_q       <= act_d;
      shadow_ok_q <= shadow_ok_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      h_q         <= h_d;
      v_q         <= v_d;
      bar_q       <= bar_d;
      pos_q       <= pos_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
    end
  end

  assign setup__ACK  = ack_q;
  assign param_err   = err_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign pixel       = pix_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: directed raster checks plus random setups against a frame-position model.
`timescale 1ns/1ps
module tb_hdmi_timing_gen;

  localparam logic HS_POL = 1'b1;
  localparam logic VS_POL = 1'b1;
  localparam int   DW     = 36;
  localparam int   CW     = DW / 3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  logic ena  = 1'b0;
  int   f[8];

  logic [15:0] s_ahEnd, s_ahFE, s_avEnd, s_avFE;
  logic [7:0]  s_ahBS, s_ahSW, s_avBS, s_avSW;
  assign s_ahEnd = 16'(f[0]);
  assign s_ahFE  = 16'(f[1]);
  assign s_ahBS  = 8'(f[2]);
  assign s_ahSW  = 8'(f[3]);
  assign s_avEnd = 16'(f[4]);
  assign s_avFE  = 16'(f[5]);
  assign s_avBS  = 8'(f[6]);
  assign s_avSW  = 8'(f[7]);

  logic          setup__ACK, param_err, hs, vs, de, frame_start;
  logic [15:0]   x, y;
  logic [DW-1:0] pixel;

  hdmi_timing_gen #(.HS_POL(HS_POL), .VS_POL(VS_POL), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .nRST(nRST), .setup__ENA(ena),
    .setup__ahEnd(s_ahEnd), .setup__ahFrontEnd(s_ahFE),
    .setup__ahBackSync(s_ahBS), .setup__ahSyncWidth(s_ahSW),
    .setup__avEnd(s_avEnd), .setup__avFrontEnd(s_avFE),
    .setup__avBackSync(s_avBS), .setup__avSyncWidth(s_avSW),
    .setup__ACK(setup__ACK), .param_err(param_err),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .pixel(pixel)
  );

  always #5 CLK = ~CLK;

  // Model: raster described as a linear position p within the frame
  int            m_sh[8], m_act[8], m_p;
  bit            m_ok, m_run;
  logic          m_ack, m_err, m_hs, m_vs, m_de, m_fs;
  logic [15:0]   m_x, m_y;
  logic [DW-1:0] m_pix;
  int            n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit f_ok();
    return f[0] != 0 && f[1] != 0 && f[1] + f[2] + f[3] < f[0] &&
           f[4] != 0 && f[5] != 0 && f[5] + f[6] + f[7] < f[4];
  endfunction

  task automatic model_reset();
    m_run = 0; m_ok = 0; m_p = 0;
    m_ack = 1'b0; m_err = 1'b0; m_hs = ~HS_POL; m_vs = ~VS_POL;
    m_de = 1'b0; m_fs = 1'b0; m_x = '0; m_y = '0; m_pix = '0;
    foreach (m_sh[i]) begin m_sh[i] = 0; m_act[i] = 0; end
  endtask

  task automatic model_edge();
    int h, v, bw, bar;
    int pre_sh[8];
    bit pre_go;
    logic [2:0] b3;
    if (!nRST) begin
      model_reset();
    end else begin
      pre_go = m_ack && m_ok;
      foreach (pre_sh[i]) pre_sh[i] = m_sh[i];
      if (m_run) begin
        h = m_p % m_act[0];
        v = m_p / m_act[0];
        m_de = (h < m_act[1]) && (v < m_act[5]);
        m_hs = (h >= m_act[0] - m_act[2] - m_act[3] && h < m_act[0] - m_act[2]) ? HS_POL : ~HS_POL;
        m_vs = (v >= m_act[4] - m_act[6] - m_act[7] && v < m_act[4] - m_act[6]) ? VS_POL : ~VS_POL;
        m_fs = (m_p == 0);
        if (m_de) begin
          m_x = 16'(h);
          m_y = 16'(v);
          bw  = m_act[1] / 8;
          bar = (bw == 0) ? 7 : h / bw;
          if (bar > 7) bar = 7;
          b3 = 3'(bar);
          m_pix = {{CW{b3[2]}}, {CW{b3[1]}}, {CW{b3[0]}}};
        end else begin
          m_pix = '0;
        end
      end else begin
        m_de = 1'b0; m_hs = ~HS_POL; m_vs = ~VS_POL; m_fs = 1'b0; m_pix = '0;
      end
      m_ack = ena;
      if (ena) begin
        if (f_ok()) begin
          foreach (f[i]) m_sh[i] = f[i];
          m_ok = 1; m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (!m_run) begin
        if (pre_go) begin
          m_run = 1; m_p = 0;
          foreach (pre_sh[i]) m_act[i] = pre_sh[i];
        end
      end else begin
        m_p++;
        if (m_p == m_act[0] * m_act[4]) begin
          m_p = 0;
          foreach (pre_sh[i]) m_act[i] = pre_sh[i];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
    chk("cyc", {setup__ACK, param_err, hs, vs, de, frame_start, x, y, pixel},
               {m_ack, m_err, m_hs, m_vs, m_de, m_fs, m_x, m_y, m_pix});
  endtask

  task automatic setup(input int ae, input int afe, input int abs, input int asw,
                       input int ve, input int vfe, input int vbs, input int vsw);
    f[0] = ae; f[1] = afe; f[2] = abs; f[3] = asw;
    f[4] = ve; f[5] = vfe; f[6] = vbs; f[7] = vsw;
    ena = 1'b1;
    tick();
    ena = 1'b0;
  endtask

  task automatic rand_cfg();
    f[0] = $urandom_range(8, 40);
    f[1] = $urandom_range(1, f[0]);
    f[2] = $urandom_range(0, 4);
    f[3] = $urandom_range(1, 4);
    f[4] = $urandom_range(3, 16);
    f[5] = $urandom_range(1, f[4]);
    f[6] = $urandom_range(0, 2);
    f[7] = $urandom_range(1, 2);
    if ($urandom_range(0, 15) == 0) f[0] = 0;
    if ($urandom_range(0, 15) == 0) f[5] = 0;
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    tick();
    while (frame_start !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, frame_start, 1'b1);
  endtask

  initial begin
    int acks, n_de, n_hs, n_vs, t0;
    logic [19:0] hmask;
    logic [9:0]  vmask;
    model_reset();
    repeat (3) tick();
    chk("reset", {setup__ACK, param_err, hs, vs, de, frame_start, pixel},
                 {1'b0, 1'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, 36'd0});
    #2 nRST = 1'b1;

    // T1: idle with no setup
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (setup__ACK) acks++;
    end
    chk("t1_no_ack", acks, 0);
    chk("t1_idle", {de, hs, vs}, {1'b0, ~HS_POL, ~VS_POL});

    // T2: basic raster
    setup(20, 12, 2, 3, 10, 6, 1, 2);
    chk("t2_ack", setup__ACK, 1'b1);
    wait_fs("t2_fs");
    n_de = 0; n_hs = 0; n_vs = 0; hmask = '0; vmask = '0;
    for (int k = 0; k < 200; k++) begin
      if (de) n_de++;
      if (hs == HS_POL) n_hs++;
      if (vs == VS_POL) n_vs++;
      if (k < 20 && hs == HS_POL) hmask[k] = 1'b1;
      if (k % 20 == 0 && vs == VS_POL) vmask[k / 20] = 1'b1;
      tick();
    end
    chk("t2_period", frame_start, 1'b1);
    chk("t2_de_cnt", n_de, 72);
    chk("t2_hs_cnt", n_hs, 30);
    chk("t2_vs_cnt", n_vs, 40);
    chk("t2_hs_pos", hmask, 20'h38000);
    chk("t2_vs_pos", vmask, 10'h180);

    // T3: rejected setup keeps timing
    setup(20, 18, 2, 3, 10, 6, 1, 2);
    chk("t3_ack", setup__ACK, 1'b1);
    chk("t3_err", param_err, 1'b1);
    wait_fs("t3_fs0");
    t0 = cyc;
    wait_fs("t3_fs1");
    chk("t3_len", cyc - t0, 200);
    setup(20, 12, 2, 3, 10, 6, 1, 2);
    chk("t3_err_clr", param_err, 1'b0);

    // T4: mid-frame change waits for the boundary
    wait_fs("t4_fs0");
    t0 = cyc;
    repeat (50) tick();
    setup(24, 12, 2, 3, 10, 6, 1, 2);
    wait_fs("t4_fs1");
    chk("t4_old_len", cyc - t0, 200);
    t0 = cyc;
    wait_fs("t4_fs2");
    chk("t4_new_len", cyc - t0, 240);

    // T5: setup on the exact boundary cycle
    repeat (238) tick();
    setup(30, 16, 2, 3, 9, 5, 1, 1);
    chk("t5_ack", setup__ACK, 1'b1);
    tick();
    chk("t5_fs", frame_start, 1'b1);
    t0 = cyc;
    wait_fs("t5_fs1");
    chk("t5_old_len", cyc - t0, 240);
    t0 = cyc;
    wait_fs("t5_fs2");
    chk("t5_new_len", cyc - t0, 270);

    // T6: bars of 2 px, then reset with an ACK pending
    chk("t6_x0", {x, pixel}, {16'd0, 36'd0});
    tick();
    chk("t6_x1", {x, pixel}, {16'd1, 36'd0});
    tick();
    chk("t6_x2", {x, pixel}, {16'd2, 36'h000000fff});
    repeat (12) tick();
    chk("t6_x14", {x, pixel}, {16'd14, 36'hfffffffff});
    f[0] = 30; f[1] = 16; f[2] = 2; f[3] = 3; f[4] = 9; f[5] = 5; f[6] = 1; f[7] = 1;
    ena = 1'b1;
    #2 nRST = 1'b0;
    #1;
    model_reset();
    chk("t6_async", {setup__ACK, hs, vs, de, frame_start, pixel},
                    {1'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, 36'd0});
    tick();
    ena = 1'b0;
    tick();
    #3 nRST = 1'b1;
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (setup__ACK) acks++;
    end
    chk("t6_no_ack", acks, 0);
    chk("t6_idle", de, 1'b0);

    // Random setups at random times, including rejected ones
    setup(20, 12, 2, 3, 10, 6, 1, 2);
    for (int r = 0; r < 4000; r++) begin
      if ($urandom_range(0, 59) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
          rand_cfg();
          ena = 1'b1;
          tick();
          ena = 1'b0;
        end
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
